// File: rtl/etroc_readout_pkg.sv
// Shared definitions for the ETROC2 readout path (frame gearbox and bit extender).
package etroc_readout_pkg;

  localparam int unsigned FRAME_W = 40;
  localparam int unsigned RES_W   = 39;
  localparam int unsigned COMB_W  = 72;
  localparam int unsigned DOUT_W  = 32;
  localparam int unsigned POS_W   = 6;

  localparam logic [FRAME_W-1:0] IDLE_FRAME = 40'h3C5C_0000_00;

  typedef enum logic [1:0] {
    RATE_320  = 2'b00,
    RATE_640  = 2'b01,
    RATE_1280 = 2'b10
  } rate_e;

  // Bits consumed per 40 MHz cycle; 2'b11 is treated as the 1280 Mbps rate.
  function automatic logic [POS_W-1:0] rate2width(input logic [1:0] rate);
    logic [POS_W-1:0] w;
    case (rate)
      RATE_320: w = POS_W'(8);
      RATE_640: w = POS_W'(16);
      default:  w = POS_W'(32);
    endcase
    return w;
  endfunction

endpackage

// File: rtl/gearbox_merge.sv
// Combinational core: appends a frame to the residual bits and peels off one word.
module gearbox_merge
  import etroc_readout_pkg::*;
(
  input  logic [RES_W-1:0]   res,
  input  logic [POS_W-1:0]   cnt,
  input  logic               load,
  input  logic [FRAME_W-1:0] src,
  input  logic [POS_W-1:0]   width,
  output logic [DOUT_W-1:0]  dout_nxt,
  output logic [RES_W-1:0]   res_nxt
);

  logic [FRAME_W-1:0] rev;
  logic [COMB_W-1:0]  keep_mask;
  logic [COMB_W-1:0]  comb;

  // Build the transmit-ordered buffer, then select the low W bits and shift the rest down.
  always_comb begin
    rev       = '0;
    keep_mask = '0;
    comb      = '0;
    dout_nxt  = '0;
    res_nxt   = '0;

    // Bit 39 of the frame goes out first, so it lands at the lowest free index.
    for (int k = 0; k < FRAME_W; k++) begin
      rev[k] = src[FRAME_W-1-k];
    end

    keep_mask = (COMB_W'(1) << cnt) - COMB_W'(1);
    comb      = COMB_W'(res) & keep_mask;
    if (load) begin
      comb = comb | (COMB_W'(rev) << cnt);
    end

    case (width)
      POS_W'(8):  dout_nxt[7:0]  = comb[7:0];
      POS_W'(16): dout_nxt[15:0] = comb[15:0];
      default:    dout_nxt       = comb[31:0];
    endcase

    res_nxt = RES_W'(comb >> width);
  end

endmodule

// File: rtl/frame_gearbox.sv
// 40-bit frame to 8/16/32-bit word gearbox with idle insertion and rate-change flush.
module frame_gearbox
  import etroc_readout_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk40,
  input  logic               rstn,
  input  logic [1:0]         dataRate,
  input  logic [FRAME_W-1:0] frameData,
  input  logic               frameValid,
  output logic               frameReady,
  output logic [DOUT_W-1:0]  dout,
  output logic               idleInserted,
  output logic               rateChanged,
  output logic [CNT_W-1:0]   idleCnt
);

  logic [1:0]         rate_q;
  logic [POS_W-1:0]   cnt_q;
  logic [RES_W-1:0]   res_q;
  logic [DOUT_W-1:0]  dout_q;
  logic               idle_q;
  logic               rchg_q;
  logic [CNT_W-1:0]   idle_cnt_q;

  logic [POS_W-1:0]   width;
  logic               flush;
  logic               load;
  logic               idle_load;
  logic [FRAME_W-1:0] src;
  logic [POS_W-1:0]   cnt_nxt;
  logic [DOUT_W-1:0]  dout_nxt;
  logic [RES_W-1:0]   res_nxt;

  // Per-cycle control: word width, load decision, source select and next count.
  always_comb begin
    width     = rate2width(rate_q);
    flush     = (dataRate != rate_q);
    load      = (cnt_q < width);
    src       = frameValid ? frameData : IDLE_FRAME;
    idle_load = load & ~frameValid & ~flush;
    // Intermediate sum may wrap in POS_W bits; the final value is always 0..39.
    cnt_nxt   = cnt_q + (load ? POS_W'(FRAME_W) : POS_W'(0)) - width;
    frameReady = rstn & load & frameValid & ~flush;
  end

  gearbox_merge u_merge (
    .res      (res_q),
    .cnt      (cnt_q),
    .load     (load),
    .src      (src),
    .width    (width),
    .dout_nxt (dout_nxt),
    .res_nxt  (res_nxt)
  );

  // State update; a rate change discards buffered bits and emits one zero word.
  always_ff @(posedge clk40 or negedge rstn) begin
    if (!rstn) begin
      rate_q     <= RATE_1280;
      cnt_q      <= '0;
      res_q      <= '0;
      dout_q     <= '0;
      idle_q     <= 1'b0;
      rchg_q     <= 1'b0;
      idle_cnt_q <= '0;
    end else if (flush) begin
      rate_q     <= dataRate;
      cnt_q      <= '0;
      res_q      <= '0;
      dout_q     <= '0;
      idle_q     <= 1'b0;
      rchg_q     <= 1'b1;
    end else begin
      cnt_q      <= cnt_nxt;
      res_q      <= res_nxt;
      dout_q     <= dout_nxt;
      idle_q     <= idle_load;
      rchg_q     <= 1'b0;
      if (idle_load && (idle_cnt_q != {CNT_W{1'b1}})) begin
        idle_cnt_q <= idle_cnt_q + CNT_W'(1);
      end
    end
  end

  assign dout         = dout_q;
  assign idleInserted = idle_q;
  assign rateChanged  = rchg_q;
  assign idleCnt      = idle_cnt_q;

endmodule

// File: tb/tb_frame_gearbox.sv
// Directed bench for frame_gearbox built with a 4-bit idle counter.
module tb_frame_gearbox;

  logic        clk40 = 1'b0;
  logic        rstn;
  logic [1:0]  dataRate;
  logic [39:0] frameData;
  logic        frameValid;
  logic        frameReady;
  logic [31:0] dout;
  logic        idleInserted;
  logic        rateChanged;
  logic [3:0]  idleCnt;

  int checks = 0;
  int errors = 0;

  // Hand-computed patterns (dout[0] is the first transmitted bit).
  logic [31:0] w32_dout [5] = '{32'h0000_00FF, 32'h0000_FF00, 32'h00FF_0000, 32'hFF00_0000, 32'h0};
  logic        w32_rdy  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [31:0] w8_dout  [5] = '{32'h01, 32'h00, 32'h00, 32'h00, 32'h80};
  logic        w8_rdy   [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [31:0] idle_dout[5] = '{32'h3A3C, 32'h0000, 32'h3C00, 32'h003A, 32'h0000};
  logic        idle_pls [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  frame_gearbox #(.CNT_W(4)) dut (
    .clk40        (clk40),
    .rstn         (rstn),
    .dataRate     (dataRate),
    .frameData    (frameData),
    .frameValid   (frameValid),
    .frameReady   (frameReady),
    .dout         (dout),
    .idleInserted (idleInserted),
    .rateChanged  (rateChanged),
    .idleCnt      (idleCnt)
  );

  always #5 clk40 = ~clk40;

  task automatic step();
    @(posedge clk40);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rstn       = 1'b0;
    dataRate   = 2'b10;
    frameValid = 1'b1;
    frameData  = 40'hFF_0000_0000;

    // Reset held for three cycles
    step(); step(); step();
    chk("rst_dout", dout, 32'h0);
    chk("rst_idlecnt", 32'(idleCnt), 32'h0);
    chk("rst_ready", 32'(frameReady), 32'h0);
    chk("rst_idlepulse", 32'(idleInserted), 32'h0);
    chk("rst_ratechg", 32'(rateChanged), 32'h0);

    rstn = 1'b1;
    #1;
    chk("rel_ready", 32'(frameReady), 32'h1);

    // 32-bit words from a continuous frame stream
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("w32_ready%0d", i), 32'(frameReady), 32'(w32_rdy[i % 5]));
      step();
      chk($sformatf("w32_dout%0d", i), dout, w32_dout[i % 5]);
    end
    chk("w32_noidle", 32'(idleCnt), 32'h0);

    // Switch to 8 bits per cycle; the switch cycle is a flush
    dataRate  = 2'b00;
    frameData = 40'h80_0000_0001;
    #1;
    chk("w8_flush_ready", 32'(frameReady), 32'h0);
    step();
    chk("w8_flush_dout", dout, 32'h0);
    chk("w8_ratechg", 32'(rateChanged), 32'h1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("w8_ready%0d", i), 32'(frameReady), 32'(w8_rdy[i]));
      step();
      chk($sformatf("w8_dout%0d", i), dout, w8_dout[i]);
      if (i == 0) chk("w8_ratechg_clr", 32'(rateChanged), 32'h0);
    end

    // 16 bits per cycle with no frames: idle frames only, flush wins over underflow
    dataRate   = 2'b01;
    frameValid = 1'b0;
    #1;
    chk("idle_flush_ready", 32'(frameReady), 32'h0);
    step();
    chk("idle_flush_pulse", 32'(idleInserted), 32'h0);
    chk("idle_flush_cnt", 32'(idleCnt), 32'h0);
    chk("idle_flush_ratechg", 32'(rateChanged), 32'h1);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("idle_ready%0d", i), 32'(frameReady), 32'h0);
      step();
      chk($sformatf("idle_dout%0d", i), dout, idle_dout[i % 5]);
      chk($sformatf("idle_pulse%0d", i), 32'(idleInserted), 32'(idle_pls[i % 5]));
    end
    chk("idle_cnt4", 32'(idleCnt), 32'h4);

    // Back to 32 bits, run part of a frame, then change to 16 bits mid-stream
    dataRate   = 2'b10;
    frameValid = 1'b1;
    frameData  = 40'hFF_0000_0000;
    step();
    chk("mid_flush1_dout", dout, 32'h0);
    step();
    chk("mid_w32_dout0", dout, 32'h0000_00FF);
    step();
    chk("mid_w32_dout1", dout, 32'h0000_FF00);
    dataRate  = 2'b01;
    frameData = 40'hF0_0000_0000;
    #1;
    chk("mid_flush_ready", 32'(frameReady), 32'h0);
    step();
    chk("mid_flush_dout", dout, 32'h0);
    chk("mid_flush_ratechg", 32'(rateChanged), 32'h1);
    chk("mid_fresh_ready", 32'(frameReady), 32'h1);
    step();
    chk("mid_fresh_dout0", dout, 32'h0000_000F);
    chk("mid_ratechg_clr", 32'(rateChanged), 32'h0);
    chk("mid_next_ready", 32'(frameReady), 32'h0);
    step();
    chk("mid_fresh_dout1", dout, 32'h0);
    chk("mid_idlecnt_hold", 32'(idleCnt), 32'h4);

    // Counter saturation: 20 idle loads on top of 4 must stop at 15
    dataRate   = 2'b10;
    frameValid = 1'b0;
    step();
    chk("sat_flush_cnt", 32'(idleCnt), 32'h4);
    for (int i = 0; i < 25; i++) step();
    chk("sat_idlecnt", 32'(idleCnt), 32'hF);

    // Async reset mid-frame, away from any clock edge
    frameValid = 1'b1;
    frameData  = 40'hFF_0000_0000;
    step(); step();
    chk("pre_rst_dout", dout, 32'h0000_FF00);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_dout", dout, 32'h0);
    chk("arst_idlecnt", 32'(idleCnt), 32'h0);
    chk("arst_ready", 32'(frameReady), 32'h0);
    chk("arst_idlepulse", 32'(idleInserted), 32'h0);
    dataRate = 2'b00;
    step();
    rstn = 1'b1;
    #1;
    chk("post_rst_flush_ready", 32'(frameReady), 32'h0);
    step();
    chk("post_rst_ratechg", 32'(rateChanged), 32'h1);
    chk("post_rst_dout", dout, 32'h0);
    chk("post_rst_ready", 32'(frameReady), 32'h1);
    step();
    chk("post_rst_first", dout, 32'h0000_00FF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
